// File: rtl/vnu_control_unit.sv
// Layer sequencer for the variable-node unit: paces C2V fetch, VNU pipeline, V2C shift and write-back per layer.
// Optional macro VNU_EARLY_STOP_EN: end the frame early when all parity checks pass at the last layer.
module vnu_control_unit #(
    parameter int unsigned LAYER_NUM          = 3,
    parameter int unsigned MAX_ITER           = 8,
    parameter int unsigned MEM_RD_LEVEL       = 2,
    parameter int unsigned VNU_PIPELINE_LEVEL = 3,
    parameter int unsigned PERMUTATION_LEVEL  = 2,
    localparam int unsigned LAYER_W = $clog2(LAYER_NUM),
    localparam int unsigned ITER_W  = $clog2(MAX_ITER + 1)
) (
    input  logic               read_clk,
    input  logic               rstn,
    input  logic               fsm_en,
    input  logic               c2v_mem_we,
    input  logic               all_sat,
    output logic               c2v_mem_fetch,
    output logic               vnu_rd,
    output logic               v2c_bs_en,
    output logic               v2c_mem_we,
    output logic               vnu_update_pend,
    output logic               layer_finish,
    output logic               termination,
    output logic               c2v_ovf,
    output logic [LAYER_W-1:0] layer_idx,
    output logic [ITER_W-1:0]  iter_cnt,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MEM_FETCH = 3'd1,
        VNU_PIPE  = 3'd2,
        BS_WB     = 3'd3,
        MEM_WB    = 3'd4,
        LAYER_END = 3'd5
    } state_e;

    localparam logic [MEM_RD_LEVEL-1:0]       FETCH_ONE = MEM_RD_LEVEL'(1);
    localparam logic [VNU_PIPELINE_LEVEL-1:0] PIPE_ONE  = VNU_PIPELINE_LEVEL'(1);
    localparam logic [PERMUTATION_LEVEL-1:0]  BS_ONE    = PERMUTATION_LEVEL'(1);
    localparam logic [LAYER_W-1:0]            LAST_LAYER = LAYER_W'(LAYER_NUM - 1);
    localparam logic [ITER_W-1:0]             LAST_ITER  = ITER_W'(MAX_ITER - 1);

    state_e                        state_q, state_d;
    logic [MEM_RD_LEVEL-1:0]       fetch_q, fetch_d;
    logic [VNU_PIPELINE_LEVEL-1:0] pipe_q, pipe_d;
    logic [PERMUTATION_LEVEL-1:0]  bs_q, bs_d;
    logic [LAYER_W-1:0]            layer_q, layer_d;
    logic [ITER_W-1:0]             iter_q, iter_d;
    logic                          pend_q, pend_d;
    logic                          ovf_q, ovf_d;
    logic                          term_q, term_d;
    logic                          fetch_out_q, fetch_out_d;
    logic                          rd_q, rd_d;
    logic                          bs_out_q, bs_out_d;
    logic                          mwe_q, mwe_d;
    logic                          upd_q, upd_d;
    logic                          lf_q, lf_d;
    logic                          last_layer;
    logic                          frame_done;

    assign last_layer = (layer_q == LAST_LAYER);

`ifdef VNU_EARLY_STOP_EN
    assign frame_done = last_layer && ((iter_q == LAST_ITER) || all_sat);
`else
    logic unused_all_sat;
    assign unused_all_sat = all_sat;
    assign frame_done     = last_layer && (iter_q == LAST_ITER);
`endif

    // Next-state, bookkeeping and registered-output decode
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        layer_d = layer_q;
        iter_d  = iter_q;
        term_d  = 1'b0;

        if (!fsm_en) begin
            state_d = IDLE;
            pend_d  = 1'b0;
            ovf_d   = 1'b0;
            layer_d = '0;
            iter_d  = '0;
        end else begin
            // One-deep queue for a write-back that lands while a layer is running
            if (c2v_mem_we) begin
                if (pend_q) begin
                    ovf_d = 1'b1;
                end else if (state_q != IDLE) begin
                    pend_d = 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (c2v_mem_we || pend_q) begin
                        state_d = MEM_FETCH;
                        pend_d  = 1'b0;
                    end
                end
                MEM_FETCH: if (fetch_q[MEM_RD_LEVEL-1])       state_d = VNU_PIPE;
                VNU_PIPE:  if (pipe_q[VNU_PIPELINE_LEVEL-1])  state_d = BS_WB;
                BS_WB:     if (bs_q[PERMUTATION_LEVEL-1])     state_d = MEM_WB;
                MEM_WB:    state_d = LAYER_END;
                LAYER_END: begin
                    state_d = IDLE;
                    if (frame_done) begin
                        layer_d = '0;
                        iter_d  = '0;
                        pend_d  = 1'b0;
                        term_d  = 1'b1;
                    end else if (last_layer) begin
                        layer_d = '0;
                        iter_d  = ITER_W'(iter_q + 1'b1);
                    end else begin
                        layer_d = LAYER_W'(layer_q + 1'b1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Stage timers rotate only while staying in their stage
        fetch_d = (state_q == MEM_FETCH && state_d == MEM_FETCH)
                ? MEM_RD_LEVEL'((fetch_q << 1) | (fetch_q >> (MEM_RD_LEVEL - 1))) : FETCH_ONE;
        pipe_d  = (state_q == VNU_PIPE && state_d == VNU_PIPE)
                ? VNU_PIPELINE_LEVEL'((pipe_q << 1) | (pipe_q >> (VNU_PIPELINE_LEVEL - 1))) : PIPE_ONE;
        bs_d    = (state_q == BS_WB && state_d == BS_WB)
                ? PERMUTATION_LEVEL'((bs_q << 1) | (bs_q >> (PERMUTATION_LEVEL - 1))) : BS_ONE;

        fetch_out_d = (state_d == MEM_FETCH) && fetch_d[0];
        rd_d        = (state_d == VNU_PIPE);
        bs_out_d    = (state_d == BS_WB) && bs_d[0];
        mwe_d       = (state_d == MEM_WB);
        lf_d        = (state_d == LAYER_END);
        upd_d       = (state_d != IDLE) || pend_d;
    end

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            fetch_q     <= FETCH_ONE;
            pipe_q      <= PIPE_ONE;
            bs_q        <= BS_ONE;
            layer_q     <= '0;
            iter_q      <= '0;
            pend_q      <= 1'b0;
            ovf_q       <= 1'b0;
            term_q      <= 1'b0;
            fetch_out_q <= 1'b0;
            rd_q        <= 1'b0;
            bs_out_q    <= 1'b0;
            mwe_q       <= 1'b0;
            upd_q       <= 1'b0;
            lf_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_q     <= fetch_d;
            pipe_q      <= pipe_d;
            bs_q        <= bs_d;
            layer_q     <= layer_d;
            iter_q      <= iter_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            term_q      <= term_d;
            fetch_out_q <= fetch_out_d;
            rd_q        <= rd_d;
            bs_out_q    <= bs_out_d;
            mwe_q       <= mwe_d;
            upd_q       <= upd_d;
            lf_q        <= lf_d;
        end
    end

    assign c2v_mem_fetch   = fetch_out_q;
    assign vnu_rd          = rd_q;
    assign v2c_bs_en       = bs_out_q;
    assign v2c_mem_we      = mwe_q;
    assign vnu_update_pend = upd_q;
    assign layer_finish    = lf_q;
    assign termination     = term_q;
    assign c2v_ovf         = ovf_q;
    assign layer_idx       = layer_q;
    assign iter_cnt        = iter_q;
    assign state           = state_q;

endmodule

// File: tb/tb_vnu_control_unit.sv
// Bench for vnu_control_unit: directed layer scenarios plus random traffic against a layer-position model.
module tb_vnu_control_unit;

    localparam int LN = 3;
    localparam int MI = 2;
    localparam int MR = 2;
    localparam int VP = 3;
    localparam int PL = 2;
    localparam int L  = 1 + MR + VP + PL + 1 + 1 - 1; // fetch..layer_end positions, 9
`ifdef VNU_EARLY_STOP_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       read_clk = 1'b0;
    logic       rstn = 1'b0;
    logic       fsm_en = 1'b0;
    logic       c2v_mem_we = 1'b0;
    logic       all_sat = 1'b0;
    logic       c2v_mem_fetch, vnu_rd, v2c_bs_en, v2c_mem_we;
    logic       vnu_update_pend, layer_finish, termination, c2v_ovf;
    logic [1:0] layer_idx;
    logic [1:0] iter_cnt;
    logic [2:0] state;

    vnu_control_unit #(
        .LAYER_NUM(LN), .MAX_ITER(MI), .MEM_RD_LEVEL(MR),
        .VNU_PIPELINE_LEVEL(VP), .PERMUTATION_LEVEL(PL)
    ) dut (
        .read_clk(read_clk), .rstn(rstn), .fsm_en(fsm_en), .c2v_mem_we(c2v_mem_we),
        .all_sat(all_sat), .c2v_mem_fetch(c2v_mem_fetch), .vnu_rd(vnu_rd),
        .v2c_bs_en(v2c_bs_en), .v2c_mem_we(v2c_mem_we), .vnu_update_pend(vnu_update_pend),
        .layer_finish(layer_finish), .termination(termination), .c2v_ovf(c2v_ovf),
        .layer_idx(layer_idx), .iter_cnt(iter_cnt), .state(state)
    );

    always #5 read_clk = ~read_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: pos = 0 when idle, else 1..L position within the running layer
    int m_pos, m_layer, m_iter;
    bit m_pend, m_ovf, m_term;

    function automatic void model_reset();
        m_pos = 0; m_layer = 0; m_iter = 0;
        m_pend = 0; m_ovf = 0; m_term = 0;
    endfunction

    function automatic void model_step(input bit we, input bit sat, input bit en);
        bit npend, last, stop;
        if (!en) begin
            model_reset();
            return;
        end
        m_term = 0;
        npend = m_pend;
        if (we) begin
            if (m_pend) m_ovf = 1;
            else if (m_pos != 0) npend = 1;
        end
        if (m_pos == 0) begin
            if (we || m_pend) begin
                m_pos = 1;
                npend = 0;
            end
        end else if (m_pos == L) begin
            m_pos = 0;
            last = (m_layer == LN - 1);
            stop = last && ((m_iter == MI - 1) || (EARLY && sat));
            if (stop) begin
                m_layer = 0; m_iter = 0; npend = 0; m_term = 1;
            end else if (last) begin
                m_layer = 0; m_iter++;
            end else begin
                m_layer++;
            end
        end else begin
            m_pos++;
        end
        m_pend = npend;
    endfunction

    function automatic logic [14:0] model_vec();
        logic [2:0] st;
        if (m_pos == 0)                 st = 3'd0;
        else if (m_pos <= MR)           st = 3'd1;
        else if (m_pos <= MR + VP)      st = 3'd2;
        else if (m_pos <= MR + VP + PL) st = 3'd3;
        else if (m_pos == L - 1)        st = 3'd4;
        else                            st = 3'd5;
        return {st, 2'(m_layer), 2'(m_iter),
                1'(m_pos == 1), 1'(m_pos > MR && m_pos <= MR + VP), 1'(m_pos == MR + VP + 1),
                1'(m_pos == L - 1), 1'(m_pos != 0 || m_pend), 1'(m_pos == L), m_term, m_ovf};
    endfunction

    logic [14:0] obs;
    assign obs = {state, layer_idx, iter_cnt, c2v_mem_fetch, vnu_rd, v2c_bs_en, v2c_mem_we,
                  vnu_update_pend, layer_finish, termination, c2v_ovf};

    int cyc, first_lf, first_fetch, last_fetch, lf_cnt, term_cnt, rd_cnt, pend_cnt;
    int lf_layers[$];

    task automatic clear_stats();
        cyc = 0; first_lf = -1; first_fetch = -1; last_fetch = -1;
        lf_cnt = 0; term_cnt = 0; rd_cnt = 0; pend_cnt = 0;
        lf_layers.delete();
    endtask

    // Drive inputs for one cycle, advance the model at the edge, compare just after
    task automatic step(input bit we, input bit sat, input bit en);
        c2v_mem_we = we; all_sat = sat; fsm_en = en;
        @(posedge read_clk);
        model_step(we, sat, en);
        #1;
        cyc++;
        check("outs", 32'(obs), 32'(model_vec()));
        if (layer_finish) begin
            lf_cnt++;
            lf_layers.push_back(int'(layer_idx));
            if (first_lf < 0) first_lf = cyc;
        end
        if (c2v_mem_fetch) begin
            if (first_fetch < 0) first_fetch = cyc;
            last_fetch = cyc;
        end
        if (termination) term_cnt++;
        if (vnu_rd) rd_cnt++;
        if (vnu_update_pend) pend_cnt++;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #2;
        model_reset();
        check("rst_zero", 32'(obs), 32'd0);
        @(posedge read_clk);
        #1;
        check("rst_hold", 32'(obs), 32'(model_vec()));
        rstn = 1'b1;
    endtask

    // Runs n layers back to back by re-arming c2v_mem_we in each LAYER_END
    task automatic run_layers(input int n, input int sat_layer);
        int done = 0;
        int guard = 0;
        bit e;
        step(1, 0, 1);
        while (done < n && guard < 40 * n) begin
            e = (m_pos == L);
            step(e && (done < n - 1), e && (done == sat_layer - 1), 1);
            if (e) done++;
            guard++;
        end
        check("layers_timeout", 32'(done), 32'(n));
        repeat (3) step(0, 0, 1);
    endtask

    initial begin
        model_reset();
        clear_stats();
        #2;
        check("por_zero", 32'(obs), 32'd0);
        do_reset();

        // Single layer timing
        clear_stats();
        step(1, 0, 1);
        repeat (12) step(0, 0, 1);
        check("lat_fetch", 32'(first_fetch), 32'd1);
        check("lat_lf", 32'(first_lf), 32'd9);
        check("rd_cycles", 32'(rd_cnt), 32'd3);
        check("pend_cycles", 32'(pend_cnt), 32'd9);

        // Queued second write-back
        step(0, 0, 0);
        clear_stats();
        for (int i = 0; i < 25; i++) step(i == 0 || i == 4, 0, 1);
        check("pend_refetch", 32'(last_fetch), 32'd11);
        check("pend_no_ovf", 32'(c2v_ovf), 32'd0);
        check("pend_two_lf", 32'(lf_cnt), 32'd2);

        // Overrun drops the third pulse
        step(0, 0, 0);
        clear_stats();
        for (int i = 0; i < 30; i++) step(i == 0 || i == 3 || i == 5, 0, 1);
        check("ovf_set", 32'(c2v_ovf), 32'd1);
        check("ovf_lf_cnt", 32'(lf_cnt), 32'd2);
        step(0, 0, 0);
        check("ovf_clear_en", 32'(c2v_ovf), 32'd0);

        // Full frame: MAX_ITER iterations of LAYER_NUM layers
        clear_stats();
        run_layers(6, 0);
        check("frame_term", 32'(term_cnt), 32'd1);
        check("frame_lf", 32'(lf_cnt), 32'd6);
        for (int i = 0; i < lf_layers.size(); i++) check("frame_layer", 32'(lf_layers[i]), 32'(i % LN));
        check("frame_layer0", 32'(layer_idx), 32'd0);
        check("frame_iter0", 32'(iter_cnt), 32'd0);

        // all_sat in the third LAYER_END
        step(0, 0, 0);
        clear_stats();
        run_layers(3, 3);
        check("early_term", 32'(term_cnt), EARLY ? 32'd1 : 32'd0);
        check("early_iter", 32'(iter_cnt), EARLY ? 32'd0 : 32'd1);

        // Reset in the middle of a layer
        step(0, 0, 0);
        clear_stats();
        step(1, 0, 1);
        repeat (4) step(0, 0, 1);
        do_reset();
        repeat (6) step(0, 0, 1);
        check("rst_no_lf", 32'(lf_cnt), 32'd0);
        clear_stats();
        step(1, 0, 1);
        repeat (12) step(0, 0, 1);
        check("rst_resume_lf", 32'(first_lf), 32'd9);
        check("rst_resume_cnt", 32'(lf_cnt), 32'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(499, 0) == 0) do_reset();
            else step($urandom_range(7, 0) == 0, $urandom_range(3, 0) == 0,
                      $urandom_range(199, 0) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
